control_sequencer: RTL and testbench

Hardwired control unit that drives the CPU datapath's bus-select, register-load, ALU and memory-read controls. It takes over the role the stimulus bench plays today. It steps each instruction through fetch (T0–T2) and execute (T3–T6) one clock per state, and stalls in T1 until memory acknowledges the read. Decode uses the IR register's output fields. Every output is a strobe wired directly to the matching datapath port.

---
 rtl/control_pkg.sv | 61 ++++++
 rtl/control_sequencer_reg_field_decoder.sv | 12 +
 rtl/control_sequencer.sv | 176 +++++++++++++++++
 tb/tb_control_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - state encodings, opcode map and IR field layout for the control sequencer
package control_pkg;

    localparam int NUM_REGS = 16;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam logic [4:0] OP_ALU_LAST = 5'd13;
    localparam logic [4:0] OP_MUL      = 5'd14;
    localparam logic [4:0] OP_DIV      = 5'd15;
    localparam logic [4:0] OP_MFHI     = 5'd16;
    localparam logic [4:0] OP_MFLO     = 5'd17;
    localparam logic [4:0] OP_HALT     = 5'd31;

    localparam logic [3:0] ALU_MUL = 4'b1110;
    localparam logic [3:0] ALU_DIV = 4'b1111;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MULDIV,
        CLS_MFHI,
        CLS_MFLO,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    function automatic op_class_t classify(input logic [4:0] op);
        if (op <= OP_ALU_LAST)                 return CLS_ALU;
        else if (op == OP_MUL || op == OP_DIV) return CLS_MULDIV;
        else if (op == OP_MFHI)                return CLS_MFHI;
        else if (op == OP_MFLO)                return CLS_MFLO;
        else if (op == OP_HALT)                return CLS_HALT;
        else                                   return CLS_ILLEGAL;
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        if (op == OP_MUL)      return ALU_MUL;
        else if (op == OP_DIV) return ALU_DIV;
        else                   return op[3:0];
    endfunction

endpackage

// File: rtl/control_sequencer_reg_field_decoder.sv
// rtl/control_sequencer_reg_field_decoder.sv - 4-bit register field to 16-bit one-hot, gated by enable
module reg_field_decoder
    import control_pkg::*;
(
    input  logic                field,
    input  logic [3:0]          sel,
    output logic [NUM_REGS-1:0] onehot
);

    assign onehot = field ? (16'd1 << sel) : 16'd0;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute sequencer driving datapath strobes from state and IR
module control_sequencer
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] IR,
    output logic [3:0]  ALUcontrol,
    output logic        MDRead,
    output logic [15:0] RIn,
    output logic [15:0] RSelect,
    output logic        PCIn,
    output logic        PCSelect,
    output logic        MARIn,
    output logic        MDRIn,
    output logic        MDRSelect,
    output logic        IRIn,
    output logic        RYIn,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        ZLowSelect,
    output logic        ZHighSelect,
    output logic        HIIn,
    output logic        LOWIn,
    output logic        HISelect,
    output logic        LOWSelect,
    output logic        IncPC,
    output logic [3:0]  state,
    output logic        halted,
    output logic        illegal
);

    state_t      state_q;
    state_t      state_d;
    state_t      fetch_next;
    logic        halted_q;
    logic        illegal_q;
    op_class_t   cls;
    logic [4:0]  opcode;
    logic        ra_en;
    logic        rb_en;
    logic        rc_en;
    logic [15:0] rsel_b;
    logic [15:0] rsel_c;
    logic        unused_ir_low;

    assign opcode        = IR[OP_MSB:OP_LSB];
    assign cls           = classify(opcode);
    assign fetch_next    = run ? S_T0 : S_IDLE;
    assign unused_ir_low = ^IR[RC_LSB-1:0];

    assign state   = state_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;

    reg_field_decoder u_dec_ra (.field(ra_en), .sel(IR[RA_MSB:RA_LSB]), .onehot(RIn));
    reg_field_decoder u_dec_rb (.field(rb_en), .sel(IR[RB_MSB:RB_LSB]), .onehot(rsel_b));
    reg_field_decoder u_dec_rc (.field(rc_en), .sel(IR[RC_MSB:RC_LSB]), .onehot(rsel_c));

    // Rb and Rc drive the bus in different states, so OR-ing keeps RSelect one-hot.
    assign RSelect = rsel_b | rsel_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_T3 && (cls == CLS_HALT || cls == CLS_ILLEGAL))
                halted_q <= 1'b1;
            if (state_q == S_T3 && cls == CLS_ILLEGAL)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ALUcontrol  = 4'd0;
        MDRead      = 1'b0;
        PCIn        = 1'b0;
        PCSelect    = 1'b0;
        MARIn       = 1'b0;
        MDRIn       = 1'b0;
        MDRSelect   = 1'b0;
        IRIn        = 1'b0;
        RYIn        = 1'b0;
        ZLowIn      = 1'b0;
        ZHighIn     = 1'b0;
        ZLowSelect  = 1'b0;
        ZHighSelect = 1'b0;
        HIIn        = 1'b0;
        LOWIn       = 1'b0;
        HISelect    = 1'b0;
        LOWSelect   = 1'b0;
        IncPC       = 1'b0;
        ra_en       = 1'b0;
        rb_en       = 1'b0;
        rc_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                PCSelect = 1'b1;
                MARIn    = 1'b1;
                IncPC    = 1'b1;
                ZLowIn   = 1'b1;
                state_d  = S_T1;
            end
            S_T1: begin
                // PC load waits for the ack cycle so a stall cannot load it twice.
                ZLowSelect = 1'b1;
                MDRead     = 1'b1;
                MDRIn      = 1'b1;
                if (mem_ready) begin
                    PCIn    = 1'b1;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                MDRSelect = 1'b1;
                IRIn      = 1'b1;
                state_d   = S_T3;
            end
            S_T3: begin
                case (cls)
                    CLS_ALU, CLS_MULDIV: begin
                        rb_en   = 1'b1;
                        RYIn    = 1'b1;
                        state_d = S_T4;
                    end
                    CLS_MFHI: begin
                        HISelect = 1'b1;
                        ra_en    = 1'b1;
                        state_d  = fetch_next;
                    end
                    CLS_MFLO: begin
                        LOWSelect = 1'b1;
                        ra_en     = 1'b1;
                        state_d   = fetch_next;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_T4: begin
                rc_en      = 1'b1;
                ALUcontrol = alu_code(opcode);
                ZLowIn     = 1'b1;
                ZHighIn    = (cls == CLS_MULDIV);
                state_d    = S_T5;
            end
            S_T5: begin
                ZLowSelect = 1'b1;
                if (cls == CLS_MULDIV) begin
                    LOWIn   = 1'b1;
                    state_d = S_T6;
                end else begin
                    ra_en   = 1'b1;
                    state_d = fetch_next;
                end
            end
            S_T6: begin
                ZHighSelect = 1'b1;
                HIIn        = 1'b1;
                state_d     = fetch_next;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        mem_ready;
    logic [31:0] IR;
    logic [3:0]  ALUcontrol;
    logic        MDRead;
    logic [15:0] RIn;
    logic [15:0] RSelect;
    logic        PCIn, PCSelect, MARIn, MDRIn, MDRSelect, IRIn, RYIn, ZLowIn, ZHighIn;
    logic        ZLowSelect, ZHighSelect, HIIn, LOWIn, HISelect, LOWSelect, IncPC;
    logic [3:0]  state;
    logic        halted;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    logic [54:0] all_out;
    assign all_out = {ALUcontrol, MDRead, RIn, RSelect, PCIn, PCSelect, MARIn, MDRIn,
                      MDRSelect, IRIn, RYIn, ZLowIn, ZHighIn, ZLowSelect, ZHighSelect,
                      HIIn, LOWIn, HISelect, LOWSelect, IncPC, halted, illegal};

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .IR(IR),
        .ALUcontrol(ALUcontrol), .MDRead(MDRead), .RIn(RIn), .RSelect(RSelect),
        .PCIn(PCIn), .PCSelect(PCSelect), .MARIn(MARIn), .MDRIn(MDRIn),
        .MDRSelect(MDRSelect), .IRIn(IRIn), .RYIn(RYIn), .ZLowIn(ZLowIn),
        .ZHighIn(ZHighIn), .ZLowSelect(ZLowSelect), .ZHighSelect(ZHighSelect),
        .HIIn(HIIn), .LOWIn(LOWIn), .HISelect(HISelect), .LOWSelect(LOWSelect),
        .IncPC(IncPC), .state(state), .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        run = 1'b0;
        mem_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        IR = 32'h0;
        do_reset();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if (all_out !== 55'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    endtask

    task automatic test_alu_back_to_back;
        IR = 32'h01890000;
        run = 1'b1;
        mem_ready = 1'b1;
        tick();
        checks++;
        if (state !== 4'd1 || {PCSelect, MARIn, IncPC, ZLowIn} !== 4'hF || RSelect !== 16'h0)
            begin errors++; $display("FAIL alu_t0: state=%0d strobes=%b expected 1/1111", state, {PCSelect, MARIn, IncPC, ZLowIn}); end
        tick();
        checks++;
        if (state !== 4'd2 || {ZLowSelect, PCIn, MDRead, MDRIn} !== 4'hF)
            begin errors++; $display("FAIL alu_t1: state=%0d strobes=%b expected 2/1111", state, {ZLowSelect, PCIn, MDRead, MDRIn}); end
        tick();
        checks++;
        if (state !== 4'd3 || {MDRSelect, IRIn} !== 2'b11 || ZLowSelect !== 1'b0)
            begin errors++; $display("FAIL alu_t2: state=%0d strobes=%b expected 3/11", state, {MDRSelect, IRIn}); end
        tick();
        checks++;
        if (state !== 4'd4 || RSelect !== 16'h0002 || RYIn !== 1'b1 || ALUcontrol !== 4'd0)
            begin errors++; $display("FAIL alu_t3: state=%0d RSelect=%h RYIn=%b expected 4/0002/1", state, RSelect, RYIn); end
        tick();
        checks++;
        if (state !== 4'd5 || RSelect !== 16'h0004 || ALUcontrol !== 4'd0 || ZLowIn !== 1'b1 || ZHighIn !== 1'b0)
            begin errors++; $display("FAIL alu_t4: state=%0d RSelect=%h ALU=%h ZLowIn=%b ZHighIn=%b expected 5/0004/0/1/0", state, RSelect, ALUcontrol, ZLowIn, ZHighIn); end
        tick();
        checks++;
        if (state !== 4'd6 || RIn !== 16'h0008 || ZLowSelect !== 1'b1 || ALUcontrol !== 4'd0)
            begin errors++; $display("FAIL alu_t5: state=%0d RIn=%h ZLowSelect=%b expected 6/0008/1", state, RIn, ZLowSelect); end
        tick();
        checks++;
        if (state !== 4'd1) begin errors++; $display("FAIL b2b_no_bubble: got state %0d expected 1", state); end
        // second instruction: opcode 9, Ra=5, Rb=10, Rc=15; run drops mid-instruction
        IR = {5'd9, 4'd5, 4'd10, 4'd15, 15'd0};
        run = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (state !== 4'd4 || RSelect !== 16'h0400)
            begin errors++; $display("FAIL op9_t3: state=%0d RSelect=%h expected 4/0400", state, RSelect); end
        tick();
        checks++;
        if (RSelect !== 16'h8000 || ALUcontrol !== 4'd9)
            begin errors++; $display("FAIL op9_t4: RSelect=%h ALU=%h expected 8000/9", RSelect, ALUcontrol); end
        tick();
        checks++;
        if (RIn !== 16'h0020) begin errors++; $display("FAIL op9_t5: RIn=%h expected 0020", RIn); end
        tick();
        checks++;
        if (state !== 4'd0 || all_out !== 55'd0)
            begin errors++; $display("FAIL run0_idle: state=%0d outputs=%h expected 0/0", state, all_out); end
    endtask

    task automatic test_stall;
        IR = 32'h01890000;
        run = 1'b1;
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (state !== 4'd2 || PCIn !== 1'b0 || MDRIn !== 1'b1 || MDRead !== 1'b1)
                begin errors++; $display("FAIL stall_cycle%0d: state=%0d PCIn=%b MDRIn=%b MDRead=%b expected 2/0/1/1", i, state, PCIn, MDRIn, MDRead); end
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== 4'd2 || PCIn !== 1'b1 || MDRIn !== 1'b1)
            begin errors++; $display("FAIL stall_ack: state=%0d PCIn=%b expected 2/1", state, PCIn); end
        tick();
        checks++;
        if (state !== 4'd3) begin errors++; $display("FAIL stall_exit: state=%0d expected 3", state); end
        mem_ready = 1'b0;
        run = 1'b0;
        tick(); tick(); tick(); tick();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL stall_done: state=%0d expected 0", state); end
    endtask

    task automatic test_muldiv;
        int cycles;
        IR = 32'h70230000;
        run = 1'b1;
        mem_ready = 1'b1;
        tick();
        cycles = 1;
        tick(); tick(); tick();
        cycles += 3;
        checks++;
        if (state !== 4'd4 || RSelect !== 16'h0010 || RYIn !== 1'b1)
            begin errors++; $display("FAIL mul_t3: state=%0d RSelect=%h expected 4/0010", state, RSelect); end
        tick();
        cycles++;
        checks++;
        if (ALUcontrol !== 4'b1110 || ZLowIn !== 1'b1 || ZHighIn !== 1'b1 || RSelect !== 16'h0040)
            begin errors++; $display("FAIL mul_t4: ALU=%b ZLowIn=%b ZHighIn=%b RSelect=%h expected 1110/1/1/0040", ALUcontrol, ZLowIn, ZHighIn, RSelect); end
        tick();
        cycles++;
        checks++;
        if (state !== 4'd6 || LOWIn !== 1'b1 || ZLowSelect !== 1'b1 || RIn !== 16'h0)
            begin errors++; $display("FAIL mul_t5: state=%0d LOWIn=%b RIn=%h expected 6/1/0000", state, LOWIn, RIn); end
        tick();
        cycles++;
        checks++;
        if (state !== 4'd7 || HIIn !== 1'b1 || ZHighSelect !== 1'b1 || ZLowSelect !== 1'b0)
            begin errors++; $display("FAIL mul_t6: state=%0d HIIn=%b ZHighSelect=%b expected 7/1/1", state, HIIn, ZHighSelect); end
        for (int i = 0; i < 20 && state !== 4'd1; i++) begin
            tick();
            if (state !== 4'd1) cycles++;
        end
        checks++;
        if (cycles !== 7 || state !== 4'd1)
            begin errors++; $display("FAIL mul_latency: got %0d cycles (state %0d) expected 7", cycles, state); end
        IR = {5'd15, 4'd1, 4'd2, 4'd3, 15'd0};
        run = 1'b0;
        tick(); tick(); tick(); tick();
        checks++;
        if (ALUcontrol !== 4'b1111 || ZHighIn !== 1'b1)
            begin errors++; $display("FAIL div_t4: ALU=%b ZHighIn=%b expected 1111/1", ALUcontrol, ZHighIn); end
        tick(); tick(); tick();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL div_idle: state=%0d expected 0", state); end
    endtask

    task automatic test_mfhi_mflo;
        IR = 32'h8B800000;
        run = 1'b1;
        mem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        checks++;
        if (state !== 4'd4 || LOWSelect !== 1'b1 || HISelect !== 1'b0 || RIn !== 16'h0080 || RSelect !== 16'h0)
            begin errors++; $display("FAIL mflo_t3: state=%0d LOWSelect=%b RIn=%h expected 4/1/0080", state, LOWSelect, RIn); end
        tick();
        checks++;
        if (state !== 4'd1) begin errors++; $display("FAIL mflo_latency: state=%0d expected 1", state); end
        IR = {5'd16, 4'd2, 23'd0};
        run = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (HISelect !== 1'b1 || LOWSelect !== 1'b0 || RIn !== 16'h0004)
            begin errors++; $display("FAIL mfhi_t3: HISelect=%b RIn=%h expected 1/0004", HISelect, RIn); end
        tick();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL mfhi_idle: state=%0d expected 0", state); end
    endtask

    task automatic test_halt;
        int bad;
        IR = 32'hF8000000;
        run = 1'b1;
        mem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        checks++;
        if (state !== 4'd4 || halted !== 1'b0 || RYIn !== 1'b0)
            begin errors++; $display("FAIL halt_t3: state=%0d halted=%b expected 4/0", state, halted); end
        tick();
        checks++;
        if (state !== 4'd8 || halted !== 1'b1 || illegal !== 1'b0)
            begin errors++; $display("FAIL halt_enter: state=%0d halted=%b illegal=%b expected 8/1/0", state, halted, illegal); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state !== 4'd8 || all_out !== 55'd2) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL halt_hold: %0d bad cycles expected 0", bad); end
        do_reset();
        checks++;
        if (state !== 4'd0 || all_out !== 55'd0)
            begin errors++; $display("FAIL halt_reset: state=%0d outputs=%h expected 0/0", state, all_out); end
    endtask

    task automatic test_illegal;
        IR = 32'hA0000000;
        run = 1'b1;
        mem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        checks++;
        if (state !== 4'd4 || all_out !== 55'd0)
            begin errors++; $display("FAIL illegal_t3: state=%0d outputs=%h expected 4/0", state, all_out); end
        tick();
        checks++;
        if (state !== 4'd8 || halted !== 1'b1 || illegal !== 1'b1)
            begin errors++; $display("FAIL illegal_enter: state=%0d halted=%b illegal=%b expected 8/1/1", state, halted, illegal); end
        do_reset();
        checks++;
        if (halted !== 1'b0 || illegal !== 1'b0)
            begin errors++; $display("FAIL illegal_reset: halted=%b illegal=%b expected 0/0", halted, illegal); end
    endtask

    task automatic test_reset_mid;
        IR = 32'h01890000;
        run = 1'b1;
        mem_ready = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        checks++;
        if (state !== 4'd5) begin errors++; $display("FAIL rst_t4_setup: state=%0d expected 5", state); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run = 1'b0;
        checks++;
        if (state !== 4'd0 || all_out !== 55'd0)
            begin errors++; $display("FAIL rst_in_t4: state=%0d outputs=%h expected 0/0", state, all_out); end
        run = 1'b1;
        mem_ready = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (state !== 4'd2) begin errors++; $display("FAIL rst_stall_setup: state=%0d expected 2", state); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run = 1'b0;
        checks++;
        if (state !== 4'd0 || all_out !== 55'd0)
            begin errors++; $display("FAIL rst_in_stall: state=%0d outputs=%h expected 0/0", state, all_out); end
        tick();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL idle_hold: state=%0d expected 0", state); end
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        mem_ready = 1'b0;
        IR = 32'h0;
        test_reset();
        test_alu_back_to_back();
        test_stall();
        test_muldiv();
        test_mfhi_mflo();
        test_halt();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
